// File: rtl/ram_pkg.sv
// Shared definitions for the byte-enabled simple-dual-port RAM:
// read-during-write modes, clear-engine state encoding and the lane mask helper.
package ram_pkg;

  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

  // Upper bound on word width handled by byte_merge_mask.
  localparam int MAX_DATA_WIDTH = 1024;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } clr_state_e;

  // Expands one enable bit per lane into a bit mask covering that lane.
  function automatic logic [MAX_DATA_WIDTH-1:0] byte_merge_mask(
    input logic [MAX_DATA_WIDTH-1:0] byte_en,
    input int                        byte_width,
    input int                        num_bytes
  );
    logic [MAX_DATA_WIDTH-1:0] mask;
    mask = '0;
    for (int i = 0; i < MAX_DATA_WIDTH; i++) begin
      if (i < byte_width * num_bytes) begin
        mask[10'(i)] = byte_en[10'(i / byte_width)];
      end
    end
    return mask;
  endfunction

endpackage

// File: rtl/ram_clear_ctrl.sv
// Clear engine: walks every address once after reset or a Clear request,
// asserting Busy until the last word has been written.
module ram_clear_ctrl
  import ram_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 10,
  parameter int RAM_DEPTH     = 1 << ADDRESS_WIDTH
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     Clear,
  output logic                     Busy,
  output logic                     ClrWrEn,
  output logic [ADDRESS_WIDTH-1:0] ClrWrAddr
);

  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(RAM_DEPTH - 1);

  clr_state_e               state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    // NOTE: defaults first so every path assigns every output; no latches.
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ADDR) begin
          state_d = ST_READY;
          cnt_d   = '0;
        end
      end
      ST_READY: begin
        if (Clear) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign Busy      = (state_q == ST_CLEAR);
  // The array must stay untouched while Reset is held.
  assign ClrWrEn   = Busy & ~Reset;
  assign ClrWrAddr = cnt_q;

endmodule

// File: rtl/ram_sdp_be.sv
// Simple-dual-port RAM with per-byte write enables, registered read port
// with valid flag, selectable read-during-write behaviour and a clear engine.
module ram_sdp_be
  import ram_pkg::*;
#(
  parameter int DATA_WIDTH    = 16,
  parameter int ADDRESS_WIDTH = 10,
  parameter int RAM_DEPTH     = 1 << ADDRESS_WIDTH,
  parameter int BYTE_WIDTH    = 8,
  parameter int RDW_MODE      = 0,
  localparam int NUM_BYTES    = DATA_WIDTH / BYTE_WIDTH
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     Clear,
  output logic                     Busy,
  input  logic                     WrEn,
  input  logic [ADDRESS_WIDTH-1:0] WrAddr,
  input  logic [NUM_BYTES-1:0]     WrByteEn,
  input  logic [DATA_WIDTH-1:0]    WrData,
  input  logic                     RdEn,
  input  logic [ADDRESS_WIDTH-1:0] RdAddr,
  output logic [DATA_WIDTH-1:0]    RdData,
  output logic                     RdValid
);

  logic                     busy;
  logic                     clr_we;
  logic [ADDRESS_WIDTH-1:0] clr_addr;

  ram_clear_ctrl #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .RAM_DEPTH     (RAM_DEPTH)
  ) u_clear_ctrl (
    .Clk       (Clk),
    .Reset     (Reset),
    .Clear     (Clear),
    .Busy      (busy),
    .ClrWrEn   (clr_we),
    .ClrWrAddr (clr_addr)
  );

  assign Busy = busy;

  // User ports act only in READY with no Clear pending; Clear wins over both.
  logic port_open, user_we, rd_fire;
  assign port_open = ~busy & ~Clear & ~Reset;
  assign user_we   = port_open & WrEn;
  assign rd_fire   = port_open & RdEn;

  logic [DATA_WIDTH-1:0] user_mask;
  assign user_mask = DATA_WIDTH'(byte_merge_mask(MAX_DATA_WIDTH'(WrByteEn), BYTE_WIDTH, NUM_BYTES));

  logic                     mem_we;
  logic [ADDRESS_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0]    mem_wdata, mem_mask;

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = WrAddr;
    mem_wdata = WrData;
    mem_mask  = user_mask;
    if (clr_we) begin
      mem_we    = 1'b1;
      mem_addr  = clr_addr;
      mem_wdata = '0;
      mem_mask  = '1;
    end else if (user_we) begin
      mem_we = 1'b1;
    end
  end

  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

  // NOTE: the array has no reset; the clear engine provides the known state.
  always_ff @(posedge Clk) begin
    if (mem_we) begin
      mem[mem_addr] <= (mem[mem_addr] & ~mem_mask) | (mem_wdata & mem_mask);
    end
  end

  logic [DATA_WIDTH-1:0] rd_old, rd_data_d, rd_data_q;
  logic                  bypass, rd_valid_q;

  assign rd_old    = mem[RdAddr];
  assign bypass    = (RDW_MODE == RDW_NEW) && user_we && (WrAddr == RdAddr);
  assign rd_data_d = bypass ? ((rd_old & ~user_mask) | (WrData & user_mask)) : rd_old;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_fire;
      if (rd_fire) begin
        rd_data_q <= rd_data_d;
      end
    end
  end

  assign RdData  = rd_data_q;
  assign RdValid = rd_valid_q;

endmodule
